// File: rtl/decode_pkg.sv
// Shared types and constants for the instruction-decode stage: control bundle,
// opcode and ALU-operation encodings, and a control-bundle constructor.
package decode_pkg;

    localparam int OPC_W = 4;

    typedef struct packed {
        logic       RegDst;
        logic       RegWrite;
        logic       ALUSrc1;
        logic       ALUSrc2;
        logic [2:0] ALUOp;
        logic       MemWrite;
        logic       MemToReg;
        logic       illegal;
    } ctrl_t;

    localparam logic [OPC_W-1:0] OP_LOAD  = 4'd0;
    localparam logic [OPC_W-1:0] OP_STORE = 4'd1;
    localparam logic [OPC_W-1:0] OP_2     = 4'd2;
    localparam logic [OPC_W-1:0] OP_3     = 4'd3;
    localparam logic [OPC_W-1:0] OP_4     = 4'd4;
    localparam logic [OPC_W-1:0] OP_5     = 4'd5;
    localparam logic [OPC_W-1:0] OP_6     = 4'd6;
    localparam logic [OPC_W-1:0] OP_7     = 4'd7;
    localparam logic [OPC_W-1:0] OP_8     = 4'd8;
    localparam logic [OPC_W-1:0] OP_9     = 4'd9;
    localparam logic [OPC_W-1:0] OP_10    = 4'd10;
    localparam logic [OPC_W-1:0] OP_11    = 4'd11;
    localparam logic [OPC_W-1:0] OP_12    = 4'd12;
    localparam logic [OPC_W-1:0] OP_13    = 4'd13;

    localparam logic [2:0] ALUOP_0 = 3'd0;
    localparam logic [2:0] ALUOP_1 = 3'd1;
    localparam logic [2:0] ALUOP_2 = 3'd2;
    localparam logic [2:0] ALUOP_3 = 3'd3;
    localparam logic [2:0] ALUOP_4 = 3'd4;
    localparam logic [2:0] ALUOP_5 = 3'd5;
    localparam logic [2:0] ALUOP_6 = 3'd6;
    localparam logic [2:0] ALUOP_7 = 3'd7;

    localparam ctrl_t CTRL_ZERO = '{RegDst: 1'b0, RegWrite: 1'b0, ALUSrc1: 1'b0, ALUSrc2: 1'b0,
                                    ALUOp: 3'd0, MemWrite: 1'b0, MemToReg: 1'b0, illegal: 1'b0};

    function automatic ctrl_t mk_ctrl(input logic rd, input logic rw, input logic a1,
                                      input logic a2, input logic [2:0] op,
                                      input logic mw, input logic mr);
        ctrl_t c;
        c.RegDst   = rd;
        c.RegWrite = rw;
        c.ALUSrc1  = a1;
        c.ALUSrc2  = a2;
        c.ALUOp    = op;
        c.MemWrite = mw;
        c.MemToReg = mr;
        c.illegal  = 1'b0;
        return c;
    endfunction

endpackage

// File: rtl/decode_ctrl_rom.sv
// Combinational opcode-to-control map. Unmapped opcodes yield an all-zero
// bundle with illegal set.
module decode_ctrl_rom
    import decode_pkg::*;
#(
    parameter int OP_W = 4
) (
    input  logic [OP_W-1:0] opcode,
    output ctrl_t           ctrl
);

    // opcode lookup
    always_comb begin
        ctrl = CTRL_ZERO;
        case (opcode)
            OP_W'(OP_LOAD):  ctrl = mk_ctrl(1'b0, 1'b1, 1'b0, 1'b1, ALUOP_0, 1'b0, 1'b1);
            OP_W'(OP_STORE): ctrl = mk_ctrl(1'b0, 1'b0, 1'b0, 1'b1, ALUOP_0, 1'b1, 1'b0);
            OP_W'(OP_2):     ctrl = mk_ctrl(1'b1, 1'b1, 1'b0, 1'b0, ALUOP_0, 1'b0, 1'b0);
            OP_W'(OP_3):     ctrl = mk_ctrl(1'b0, 1'b1, 1'b0, 1'b1, ALUOP_0, 1'b0, 1'b0);
            OP_W'(OP_4):     ctrl = mk_ctrl(1'b1, 1'b1, 1'b0, 1'b0, ALUOP_1, 1'b0, 1'b0);
            OP_W'(OP_5):     ctrl = mk_ctrl(1'b1, 1'b1, 1'b0, 1'b0, ALUOP_2, 1'b0, 1'b0);
            OP_W'(OP_6):     ctrl = mk_ctrl(1'b0, 1'b1, 1'b0, 1'b1, ALUOP_2, 1'b0, 1'b0);
            OP_W'(OP_7):     ctrl = mk_ctrl(1'b1, 1'b1, 1'b0, 1'b0, ALUOP_3, 1'b0, 1'b0);
            OP_W'(OP_8):     ctrl = mk_ctrl(1'b0, 1'b1, 1'b0, 1'b0, ALUOP_3, 1'b0, 1'b0);
            OP_W'(OP_9):     ctrl = mk_ctrl(1'b0, 1'b1, 1'b0, 1'b1, ALUOP_4, 1'b0, 1'b0);
            OP_W'(OP_10):    ctrl = mk_ctrl(1'b0, 1'b1, 1'b0, 1'b1, ALUOP_5, 1'b0, 1'b0);
            OP_W'(OP_11):    ctrl = mk_ctrl(1'b0, 1'b0, 1'b0, 1'b0, ALUOP_6, 1'b0, 1'b0);
            OP_W'(OP_12):    ctrl = mk_ctrl(1'b0, 1'b0, 1'b0, 1'b0, ALUOP_7, 1'b0, 1'b0);
            OP_W'(OP_13):    ctrl = mk_ctrl(1'b1, 1'b1, 1'b1, 1'b0, ALUOP_2, 1'b0, 1'b0);
            default: begin
                ctrl         = CTRL_ZERO;
                ctrl.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage with valid/ready handshake. Define DECODE_HAZARD_EN
// to enable the load-use interlock (one bubble) and the saturating stall_count.
module decode_stage
    import decode_pkg::*;
#(
    parameter int INST_W     = 16,
    parameter int OP_W       = 4,
    parameter int REG_ADDR_W = 2,
    parameter int IMM_W      = 8,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [INST_W-1:0]     instruction,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OP_W-1:0]       opcode,
    output logic [REG_ADDR_W-1:0] rs_addr,
    output logic [REG_ADDR_W-1:0] rt_addr,
    output logic [REG_ADDR_W-1:0] rd_addr,
    output logic [IMM_W-1:0]      immediate,
    output logic [REG_ADDR_W-1:0] dest_addr,
    output logic                  RegDst,
    output logic                  RegWrite,
    output logic                  ALUSrc1,
    output logic                  ALUSrc2,
    output logic                  MemWrite,
    output logic                  MemToReg,
    output logic [2:0]            ALUOp,
    output logic                  illegal,
    output logic [CNT_W-1:0]      stall_count
);

    logic [OP_W-1:0]       in_opcode_s;
    logic [REG_ADDR_W-1:0] in_rs_s;
    logic [REG_ADDR_W-1:0] in_rt_s;
    logic [REG_ADDR_W-1:0] in_rd_s;
    logic [IMM_W-1:0]      in_imm_s;
    ctrl_t                 in_ctrl_s;
    logic                  hazard_s;
    logic                  in_ready_s;
    logic                  take_s;

    logic                  valid_r;
    logic [OP_W-1:0]       opcode_r;
    logic [REG_ADDR_W-1:0] rs_r;
    logic [REG_ADDR_W-1:0] rt_r;
    logic [REG_ADDR_W-1:0] rd_r;
    logic [IMM_W-1:0]      imm_r;
    logic [REG_ADDR_W-1:0] dest_r;
    ctrl_t                 ctrl_r;
    logic [CNT_W-1:0]      stall_r;

    assign in_opcode_s = instruction[INST_W-1 -: OP_W];
    assign in_rs_s     = instruction[INST_W-OP_W-1 -: REG_ADDR_W];
    assign in_rt_s     = instruction[INST_W-OP_W-REG_ADDR_W-1 -: REG_ADDR_W];
    assign in_rd_s     = instruction[INST_W-OP_W-2*REG_ADDR_W-1 -: REG_ADDR_W];
    assign in_imm_s    = instruction[IMM_W-1:0];

    decode_ctrl_rom #(
        .OP_W (OP_W)
    ) u_ctrl_rom (
        .opcode (in_opcode_s),
        .ctrl   (in_ctrl_s)
    );

`ifdef DECODE_HAZARD_EN
    logic rs_used_s;
    logic rt_used_s;

    // load-use detection against the held bundle; illegal opcodes read nothing
    always_comb begin
        rs_used_s = ~in_ctrl_s.ALUSrc1 & ~in_ctrl_s.illegal;
        rt_used_s = (~in_ctrl_s.ALUSrc2 | in_ctrl_s.MemWrite) & ~in_ctrl_s.illegal;
        hazard_s  = in_valid & valid_r & ctrl_r.MemToReg &
                    ((rs_used_s & (dest_r == in_rs_s)) | (rt_used_s & (dest_r == in_rt_s)));
    end
`else
    // interlock compiled out
    always_comb begin
        hazard_s = 1'b0;
    end
`endif

    assign in_ready_s = (~valid_r | out_ready) & ~hazard_s;
    assign take_s     = in_valid & in_ready_s;

    // output register: reset beats flush beats transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r  <= 1'b0;
            opcode_r <= {OP_W{1'b0}};
            rs_r     <= {REG_ADDR_W{1'b0}};
            rt_r     <= {REG_ADDR_W{1'b0}};
            rd_r     <= {REG_ADDR_W{1'b0}};
            imm_r    <= {IMM_W{1'b0}};
            dest_r   <= {REG_ADDR_W{1'b0}};
            ctrl_r   <= CTRL_ZERO;
        end else if (flush) begin
            valid_r <= 1'b0;
        end else if (take_s) begin
            valid_r  <= 1'b1;
            opcode_r <= in_opcode_s;
            rs_r     <= in_rs_s;
            rt_r     <= in_rt_s;
            rd_r     <= in_rd_s;
            imm_r    <= in_imm_s;
            dest_r   <= in_ctrl_s.RegDst ? in_rd_s : in_rt_s;
            ctrl_r   <= in_ctrl_s;
        end else if (out_ready) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    // bubble counter: a hazard with out_ready drains the load, leaving one empty cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_r <= {CNT_W{1'b0}};
`ifdef DECODE_HAZARD_EN
        end else if (!flush && hazard_s && out_ready && (stall_r != {CNT_W{1'b1}})) begin
            stall_r <= stall_r + {{(CNT_W-1){1'b0}}, 1'b1};
`endif
        end else begin
            stall_r <= stall_r;
        end
    end

    assign in_ready    = in_ready_s;
    assign out_valid   = valid_r;
    assign opcode      = opcode_r;
    assign rs_addr     = rs_r;
    assign rt_addr     = rt_r;
    assign rd_addr     = rd_r;
    assign immediate   = imm_r;
    assign dest_addr   = dest_r;
    assign RegDst      = ctrl_r.RegDst;
    assign RegWrite    = ctrl_r.RegWrite;
    assign ALUSrc1     = ctrl_r.ALUSrc1;
    assign ALUSrc2     = ctrl_r.ALUSrc2;
    assign ALUOp       = ctrl_r.ALUOp;
    assign MemWrite    = ctrl_r.MemWrite;
    assign MemToReg    = ctrl_r.MemToReg;
    assign illegal     = ctrl_r.illegal;
    assign stall_count = stall_r;

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised instruction-decode pipeline stage. Splits an instruction into opcode, register addresses and immediate, and maps the opcode to datapath control. Holds the result in an output register with a valid/ready handshake. Detects load-use hazards and inserts a one-cycle bubble. Sits between instruction fetch and the register-file/ALU stage.

## Interface
Parameters:
- INST_W, 16, instruction width
- OP_W, 4, opcode width
- REG_ADDR_W, 2, register address width
- IMM_W, 8, immediate width
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  discard held instruction
- in_valid  in  1  fetch offers instruction
- in_ready  out  1  stage accepts instruction
- instruction  in  INST_W  raw instruction
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  downstream accepts bundle
- opcode  out  OP_W  instruction[INST_W-1 -: OP_W]
- rs_addr, rt_addr, rd_addr  out  REG_ADDR_W each  consecutive fields below opcode, rs highest (defaults: [11:10], [9:8], [7:6])
- immediate  out  IMM_W  instruction[IMM_W-1:0]
- dest_addr  out  REG_ADDR_W  RegDst ? rd_addr : rt_addr
- RegDst, RegWrite, ALUSrc1, ALUSrc2, MemWrite, MemToReg  out  1 each  control
- ALUOp  out  3  ALU operation
- illegal  out  1  opcode has no mapping
- stall_count  out  CNT_W  bubbles inserted, saturating

## Operation
Control mapping (RegDst RegWrite ALUSrc1 ALUSrc2 ALUOp MemWrite MemToReg):
- 0 load: 0 1 0 1 0 0 1
- 1 store: 0 0 0 1 0 1 0
- 2: 1 1 0 0 0 0 0
- 3: 0 1 0 1 0 0 0
- 4: 1 1 0 0 1 0 0
- 5: 1 1 0 0 2 0 0
- 6: 0 1 0 1 2 0 0
- 7: 1 1 0 0 3 0 0
- 8: 0 1 0 0 3 0 0
- 9: 0 1 0 1 4 0 0
- 10: 0 1 0 1 5 0 0
- 11: 0 0 0 0 6 0 0
- 12: 0 0 0 0 7 0 0
- 13: 1 1 1 0 2 0 0
- Any other opcode: all zero, illegal=1. The instruction still passes through the stage.

Source use:
- rs is read when ALUSrc1=0 and the opcode is not illegal.
- rt is read when (ALUSrc2=0 or MemWrite=1) and the opcode is not illegal.

Hazard:
- Condition: in_valid, out_valid, the held bundle has MemToReg=1, and its dest_addr equals a source register the incoming instruction reads.

Handshake:
- in_ready = (~out_valid | out_ready) & ~hazard.
- Transfer in: in_valid & in_ready loads the output register.
- Transfer out with no transfer in: out_valid clears.
- Output fields stay stable while out_valid & ~out_ready.

Bubble:
- A hazard while out_ready=1 drains the load and leaves the register empty for one cycle.
- The next cycle, with no hazard, accepts the dependent instruction.
- stall_count increments once per such bubble cycle and saturates at all-ones.

Flush:
- Clears out_valid the next cycle and ignores that cycle's input transfer.
- stall_count is unchanged.

## Timing
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 instruction/cycle when out_ready=1 and there are no hazards.
- Load-use penalty: exactly 1 bubble cycle.
- Reset: out_valid=0, all control=0, illegal=0, fields=0, stall_count=0. in_ready=1 after reset.
- Precedence: rst > flush > transfer. Reset mid-hazard drops both instructions.

## Configuration
- DECODE_HAZARD_EN defined: load-use interlock and stall_count active.
- DECODE_HAZARD_EN undefined: hazard is tied 0, so in_ready = ~out_valid | out_ready and there are never any bubbles. stall_count stays 0.

## Structure
- Package decode_pkg holds the ctrl struct (RegDst, RegWrite, ALUSrc1, ALUSrc2, ALUOp, MemWrite, MemToReg, illegal), opcode constants OP_LOAD..OP_13, and ALUOp constants.
- Sub-module decode_ctrl_rom is the combinational opcode-to-ctrl map.
- decode_stage holds the output register, hazard logic and counter.

## Test plan
- Reset then 0x3542 with out_ready=1 -> next cycle out_valid=1, opcode=3, rs=1, rt=1, immediate=0x42, RegWrite=1, ALUSrc2=1, dest_addr=1.
- 0x0100 (load, dest 1) then 0x2460 (rs=1) -> in_ready=0 for one cycle, one bubble, stall_count=1. With the macro undefined, no bubble.
- Load 0x0100 then 0x2060 (rs=0, rt=0) -> no stall, back-to-back.
- out_ready=0 for 3 cycles holding 0x5E80 -> outputs stable, in_ready=0, then released on out_ready=1.
- Opcode 0xF (0xF000) -> illegal=1, all control 0, passes through.
- Flush or reset while a hazard is pending -> out_valid=0 next cycle. stall_count is unchanged on flush and 0 on reset.
